// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 8;
    localparam int CNT_W     = $clog2(N_DEFAULT);

    // Iteration counter width for an operand width n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditional ripple-carry add into acc_hi, then shift {c, s, acc_lo} right by one.
module mult_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] acc_hi,
    input  logic [N-1:0] acc_lo,
    input  logic [N-1:0] mcand,
    output logic [N-1:0] next_hi,
    output logic [N-1:0] next_lo
);

    logic [N-1:0] addend_s;
    logic [N-1:0] sum_s;
    logic [N:0]   carry_s;

    assign addend_s   = acc_lo[0] ? mcand : {N{1'b0}};
    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_s[i]       = acc_hi[i] ^ addend_s[i] ^ carry_s[i];
        assign carry_s[i + 1] = (acc_hi[i] & addend_s[i]) |
                                (acc_hi[i] & carry_s[i]) |
                                (addend_s[i] & carry_s[i]);
    end

    // The carry-out becomes the new MSB of acc_hi so no product bit is lost.
    assign next_hi = {carry_s[N], sum_s[N-1:1]};
    assign next_lo = {sum_s[0], acc_lo[N-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: N iterations of mult_step under a start/busy/done handshake.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_r;
    logic [N-1:0]     mcand_r;
    logic [N-1:0]     acc_hi_r;
    logic [N-1:0]     acc_lo_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [2*N-1:0]   product_r;
    logic [N-1:0]     next_hi_s;
    logic [N-1:0]     next_lo_s;

    mult_step #(.N(N)) u_step (
        .acc_hi  (acc_hi_r),
        .acc_lo  (acc_lo_r),
        .mcand   (mcand_r),
        .next_hi (next_hi_s),
        .next_lo (next_lo_s)
    );

    // Control FSM, iteration counter, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mcand_r   <= '0;
            acc_hi_r  <= '0;
            acc_lo_r  <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mcand_r  <= a;
                        acc_hi_r <= '0;
                        acc_lo_r <= b;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_r <= next_hi_s;
                    acc_lo_r <= next_lo_s;
                    if (cnt_r == LAST) begin
                        cnt_r     <= '0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= {next_hi_s, next_lo_s};
                        state_r   <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    // A start in the done cycle chains straight into the next run.
                    if (start) begin
                        mcand_r  <= a;
                        acc_hi_r <= '0;
                        acc_lo_r <= b;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
